// File: rtl/cim_sram_banked.sv
// Banked weight SRAM: port A read/write with byte strobes, port B read-only.
// Word-interleaved 1RW banks; same-bank conflicts favour A with a starvation guard for B.
module cim_sram_banked #(
    parameter int ADDR_WIDTH   = 17,
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_BANKS    = 4,
    parameter int READ_LAT     = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    a_req,
    input  logic                    a_we,
    input  logic [DATA_WIDTH/8-1:0] a_be,
    input  logic [ADDR_WIDTH-1:0]   a_addr,
    input  logic [DATA_WIDTH-1:0]   a_wdata,
    output logic                    a_gnt,
    output logic                    a_rvalid,
    output logic [DATA_WIDTH-1:0]   a_rdata,
    input  logic                    b_req,
    input  logic [ADDR_WIDTH-1:0]   b_addr,
    output logic                    b_gnt,
    output logic                    b_rvalid,
    output logic [DATA_WIDTH-1:0]   b_rdata,
    output logic [15:0]             conflict_cnt
);
    localparam int BANK_BITS = $clog2(NUM_BANKS);
    localparam int ROW_BITS  = ADDR_WIDTH - BANK_BITS;
    localparam int NUM_BYTES = DATA_WIDTH / 8;
    localparam int STARVE_W  = $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    logic [BANK_BITS-1:0]  w_a_bank;
    logic [BANK_BITS-1:0]  w_b_bank;
    logic [ROW_BITS-1:0]   w_a_row;
    logic [ROW_BITS-1:0]   w_b_row;
    logic                  w_conflict;
    logic                  w_force_b;
    logic                  w_a_gnt;
    logic                  w_b_gnt;
    logic [DATA_WIDTH-1:0] w_bank_rd [NUM_BANKS];

    logic [STARVE_W-1:0]   r_starve;
    logic [15:0]           r_conflict_cnt;
    logic                  r_a_v1;
    logic                  r_b_v1;
    logic [DATA_WIDTH-1:0] r_a_d1;
    logic [DATA_WIDTH-1:0] r_b_d1;
    logic                  w_a_v_out;
    logic                  w_b_v_out;
    logic [DATA_WIDTH-1:0] w_a_d_out;
    logic [DATA_WIDTH-1:0] w_b_d_out;

    assign w_a_bank = a_addr[BANK_BITS-1:0];
    assign w_b_bank = b_addr[BANK_BITS-1:0];
    assign w_a_row  = a_addr[ADDR_WIDTH-1:BANK_BITS];
    assign w_b_row  = b_addr[ADDR_WIDTH-1:BANK_BITS];

    // Arbitration: A wins a same-bank conflict unless B has lost STARVE_LIMIT in a row
    always_comb begin
        w_conflict = 1'b0;
        w_force_b  = 1'b0;
        w_a_gnt    = 1'b0;
        w_b_gnt    = 1'b0;
        if (rst) begin
            w_conflict = 1'b0;
        end else begin
            w_conflict = a_req & b_req & (w_a_bank == w_b_bank);
            w_force_b  = (r_starve == STARVE_MAX);
            w_a_gnt    = a_req & ~(w_conflict & w_force_b);
            w_b_gnt    = b_req & (~w_conflict | w_force_b);
        end
    end

    assign a_gnt = w_a_gnt;
    assign b_gnt = w_b_gnt;

    // Starvation and conflict bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve       <= {STARVE_W{1'b0}};
            r_conflict_cnt <= 16'h0000;
        end else begin
            if (!b_req || w_b_gnt) begin
                r_starve <= {STARVE_W{1'b0}};
            end else if (w_conflict && (r_starve != STARVE_MAX)) begin
                r_starve <= r_starve + STARVE_W'(1);
            end
            if (w_conflict && (r_conflict_cnt != 16'hFFFF)) begin
                r_conflict_cnt <= r_conflict_cnt + 16'd1;
            end
        end
    end

    // Each bank has one access port; grants guarantee at most one port per bank per cycle
    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        logic [DATA_WIDTH-1:0] r_mem [2**ROW_BITS];
        logic                  w_sel_a;
        logic                  w_we;
        logic [ROW_BITS-1:0]   w_row;

        assign w_sel_a      = w_a_gnt & (w_a_bank == BANK_BITS'(g));
        assign w_we         = w_sel_a & a_we;
        assign w_row        = w_sel_a ? w_a_row : w_b_row;
        assign w_bank_rd[g] = r_mem[w_row];

        // Byte-masked write
        always_ff @(posedge clk) begin
            if (w_we) begin
                for (int i = 0; i < NUM_BYTES; i++) begin
                    if (a_be[i]) begin
                        r_mem[w_row][i*8 +: 8] <= a_wdata[i*8 +: 8];
                    end
                end
            end
        end
    end

    // First read stage: capture the addressed word at the grant edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_v1 <= 1'b0;
            r_b_v1 <= 1'b0;
            r_a_d1 <= {DATA_WIDTH{1'b0}};
            r_b_d1 <= {DATA_WIDTH{1'b0}};
        end else begin
            r_a_v1 <= w_a_gnt & ~a_we;
            r_b_v1 <= w_b_gnt;
            if (w_a_gnt && !a_we) begin
                r_a_d1 <= w_bank_rd[w_a_bank];
            end
            if (w_b_gnt) begin
                r_b_d1 <= w_bank_rd[w_b_bank];
            end
        end
    end

    if (READ_LAT == 2) begin : g_lat2
        logic                  r_a_v2;
        logic                  r_b_v2;
        logic [DATA_WIDTH-1:0] r_a_d2;
        logic [DATA_WIDTH-1:0] r_b_d2;

        // Optional output register stage
        always_ff @(posedge clk) begin
            if (rst) begin
                r_a_v2 <= 1'b0;
                r_b_v2 <= 1'b0;
                r_a_d2 <= {DATA_WIDTH{1'b0}};
                r_b_d2 <= {DATA_WIDTH{1'b0}};
            end else begin
                r_a_v2 <= r_a_v1;
                r_b_v2 <= r_b_v1;
                if (r_a_v1) begin
                    r_a_d2 <= r_a_d1;
                end
                if (r_b_v1) begin
                    r_b_d2 <= r_b_d1;
                end
            end
        end

        assign w_a_v_out = r_a_v2;
        assign w_b_v_out = r_b_v2;
        assign w_a_d_out = r_a_d2;
        assign w_b_d_out = r_b_d2;
    end else begin : g_lat1
        assign w_a_v_out = r_a_v1;
        assign w_b_v_out = r_b_v1;
        assign w_a_d_out = r_a_d1;
        assign w_b_d_out = r_b_d1;
    end

    // Outputs read as zero for the whole reset cycle, including the one right after a grant
    assign a_rvalid     = w_a_v_out & ~rst;
    assign b_rvalid     = w_b_v_out & ~rst;
    assign a_rdata      = rst ? {DATA_WIDTH{1'b0}} : w_a_d_out;
    assign b_rdata      = rst ? {DATA_WIDTH{1'b0}} : w_b_d_out;
    assign conflict_cnt = rst ? 16'h0000 : r_conflict_cnt;

endmodule
